dma_bus_arbiter: RTL
====================

# dma_bus_arbiter

Sequences ownership of the shared data-memory port between the D-cache and the external DMA engine. It latches the DMA command when the device signals `dma_begin` and holds off the grant until any in-flight cache line transaction completes. It then grants the bus, counts DMA beats, and returns the bus to the CPU on `dma_end`. It sits between the D-cache's memory-side handshake and the DMA controller, and drives `bus_granted` and `dma_cmd`.

## Interface
- `WORD_SIZE`, 16, address/data word width
- `WATCHDOG_CYCLES`, 64, maximum cycles DMA may hold the bus (used only with `ARB_WATCHDOG_EN`)
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `dma_begin`  in  1  one-cycle pulse: device requests a DMA transfer
- `dma_end`  in  1  one-cycle pulse: DMA engine finished
- `bus_request`  in  1  DMA engine requests the memory bus; level, held until granted
- `cache_busy`  in  1  D-cache has a memory read/write outstanding (readM|writeM not yet done)
- `cmd_addr`  in  WORD_SIZE  DMA target base address, sampled on `dma_begin`
- `cmd_len`  in  WORD_SIZE  DMA length in words, sampled on `dma_begin`
- `dma_beat`  in  1  one word transferred by DMA this cycle
- `bus_granted`  out  1  DMA owns the data-memory port
- `cpu_stall`  out  1  D-cache must not start a new memory transaction
- `dma_cmd`  out  2*WORD_SIZE  {addr, len} command to the DMA engine
- `dma_cmd_valid`  out  1  one-cycle pulse qualifying `dma_cmd`
- `dma_error`  out  1  sticky: beat count mismatch or watchdog revoke; cleared only by reset
- `num_dma`  out  WORD_SIZE  completed DMA grants, wraps at 2^WORD_SIZE

## Operation
- States:
  - `IDLE`: CPU owns the bus.
  - `CMD`: command issued.
  - `DRAIN`: waiting for the cache to go quiet.
  - `GRANT`: DMA owns the bus.
  - `RELEASE`: one-cycle turnaround.
- IDLE → CMD on `dma_begin`:
  - latch `cmd_addr`/`cmd_len` into the command register;
  - clear the beat counter;
  - pulse `dma_cmd_valid` while in CMD.
- CMD → DRAIN unconditionally.
- In DRAIN:
  - if `bus_request` is high, assert `cpu_stall` (the cache may not start a new transaction);
  - move to GRANT on the first cycle with `bus_request` high and `cache_busy` low.
- In GRANT, `bus_granted` = 1 and `cpu_stall` = 1.
- Each `dma_beat` increments the beat counter, which saturates at all-ones.
- GRANT → RELEASE on `dma_end`:
  - if beat count ≠ latched `cmd_len`, set `dma_error`;
  - increment `num_dma`.
- RELEASE → IDLE. `bus_granted` = 0 in RELEASE; `cpu_stall` = 1 (turnaround).
- `bus_request` seen in IDLE without a prior `dma_begin` is ignored: no grant without a latched command.
- `dma_begin` outside IDLE is ignored and the command register is not overwritten.
- `dma_end` outside GRANT is ignored.
- `dma_beat` outside GRANT is ignored (not counted).

## Timing
- Reset values:
  - state IDLE;
  - `bus_granted` 0, `cpu_stall` 0;
  - `dma_cmd` 0, `dma_cmd_valid` 0;
  - `dma_error` 0, `num_dma` 0;
  - beat counter 0.
- All outputs are registered.
- `dma_begin` at edge N → `dma_cmd_valid` high in cycle N+1 only.
- Earliest grant: `bus_request` high and `cache_busy` low sampled at edge M in DRAIN → `bus_granted` high from cycle M+1.
- `dma_end` at edge K → `bus_granted` low from cycle K+1; `cpu_stall` low from cycle K+2.
- If `dma_end` and `dma_beat` occur in the same cycle, the beat is counted before the length comparison.
- `reset` asserted mid-transfer returns the block to IDLE next edge: grant drops, `num_dma` is not incremented.

## Configuration
- `ARB_WATCHDOG_EN` defined:
  - a cycle counter runs in GRANT;
  - when it reaches `WATCHDOG_CYCLES` without `dma_end`, the block forces GRANT → RELEASE, sets `dma_error`, and does not increment `num_dma`.
- `ARB_WATCHDOG_EN` undefined: no counter; GRANT is left only via `dma_end` or reset.

## Structure
- Shared package `arb_pkg`:
  - state enum `arb_state_t` (IDLE, CMD, DRAIN, GRANT, RELEASE);
  - `DMA_CMD_W` = 2*WORD_SIZE.
- One sub-module, `arb_watchdog`: a loadable down-counter with an expiry pulse, instantiated only under `ARB_WATCHDOG_EN`.
- FSM, command register, beat counter and statistics stay in the top module.

## Test plan
- Nominal transfer:
  - stimulus: reset; `dma_begin` with addr 0x01F4, len 12; `bus_request` high with `cache_busy` low; 12 beats; `dma_end`;
  - response: `dma_cmd` = 0x01F4000C with a 1-cycle valid; grant 2 cycles after `dma_begin`; `dma_error` 0; `num_dma` = 1.
- Drain:
  - stimulus: `cache_busy` held high 5 cycles after `bus_request`;
  - response: `cpu_stall` high throughout; `bus_granted` rises the cycle after `cache_busy` falls.
- Length mismatch:
  - stimulus: len 12 but only 11 beats before `dma_end`;
  - response: `dma_error` sets and stays set; bus returns to CPU; `num_dma` increments.
- Spurious inputs:
  - stimulus: `bus_request` without `dma_begin`; `dma_end` in IDLE; second `dma_begin` during GRANT;
  - response: no grant; no counter change; latched command unchanged.
- Reset mid-GRANT after 4 beats:
  - response: next cycle `bus_granted` 0, state IDLE, `num_dma` unchanged.
- With `ARB_WATCHDOG_EN` and `WATCHDOG_CYCLES` = 64:
  - stimulus: no `dma_end`;
  - response: grant drops after 64 GRANT cycles; `dma_error` = 1; `num_dma` unchanged.

Source files
------------

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared declarations for the DMA bus arbiter slice:
//   - arb_state_t   : ownership sequencing states
//   - ARB_WORD_SIZE : default address/data word width
//   - DMA_CMD_W     : width of the {addr, len} command at the default word size
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int ARB_WORD_SIZE = 16;
    localparam int DMA_CMD_W     = 2 * ARB_WORD_SIZE;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,   // CPU owns the data-memory port
        CMD     = 3'd1,   // command presented to the DMA engine
        DRAIN   = 3'd2,   // waiting for the D-cache to go quiet
        GRANT   = 3'd3,   // DMA owns the data-memory port
        RELEASE = 3'd4    // one-cycle turnaround back to the CPU
    } arb_state_t;

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// dma_bus_arbiter_if
// Bundles the D-cache / DMA-engine handshake seen by the arbiter.
//   Requests (driven by cache + DMA side, modport master):
//     dma_begin, dma_end, bus_request, cache_busy, cmd_addr, cmd_len, dma_beat
//   Responses (driven by the arbiter, modport slave):
//     bus_granted, cpu_stall, dma_cmd, dma_cmd_valid, dma_error, num_dma
// -----------------------------------------------------------------------------
interface dma_bus_arbiter_if
    import arb_pkg::*;
#(
    parameter int WORD_SIZE = ARB_WORD_SIZE
);

    logic                   dma_begin;
    logic                   dma_end;
    logic                   bus_request;
    logic                   cache_busy;
    logic [WORD_SIZE-1:0]   cmd_addr;
    logic [WORD_SIZE-1:0]   cmd_len;
    logic                   dma_beat;

    logic                   bus_granted;
    logic                   cpu_stall;
    logic [2*WORD_SIZE-1:0] dma_cmd;
    logic                   dma_cmd_valid;
    logic                   dma_error;
    logic [WORD_SIZE-1:0]   num_dma;

    modport master (
        output dma_begin, dma_end, bus_request, cache_busy,
               cmd_addr, cmd_len, dma_beat,
        input  bus_granted, cpu_stall, dma_cmd, dma_cmd_valid,
               dma_error, num_dma
    );

    modport slave (
        input  dma_begin, dma_end, bus_request, cache_busy,
               cmd_addr, cmd_len, dma_beat,
        output bus_granted, cpu_stall, dma_cmd, dma_cmd_valid,
               dma_error, num_dma
    );

endinterface

// File: rtl/dma_bus_arbiter_watchdog.sv
// -----------------------------------------------------------------------------
// arb_watchdog
// Loadable down-counter that flags expiry while enabled at zero.
//   clk, reset : clock and synchronous active-high reset
//   load       : load load_val (has priority over counting)
//   load_val   : value loaded, i.e. number of enabled cycles minus one
//   en         : count down while high
//   expired    : high during the enabled cycle in which the count is zero
// -----------------------------------------------------------------------------
module arb_watchdog
    import arb_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = en && !load && (count == '0);

endmodule

// File: rtl/dma_bus_arbiter.sv
// -----------------------------------------------------------------------------
// dma_bus_arbiter
// Hands the shared data-memory port between the D-cache and the DMA engine:
// latches the DMA command on dma_begin, waits for the cache to drain, grants
// the bus, counts beats and returns the bus to the CPU on dma_end.
//   clk, reset : clock and synchronous active-high reset
//   bus        : dma_bus_arbiter_if.slave (requests in, grant/stall/cmd out)
// Parameters: WORD_SIZE (word width), WATCHDOG_CYCLES (grant time limit).
// Build option: define ARB_WATCHDOG_EN to revoke a grant that is held for
// WATCHDOG_CYCLES cycles without dma_end.
// -----------------------------------------------------------------------------
module dma_bus_arbiter
    import arb_pkg::*;
#(
    parameter int WORD_SIZE       = ARB_WORD_SIZE,
    parameter int WATCHDOG_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    dma_bus_arbiter_if.slave   bus
);

    arb_state_t             state;
    arb_state_t             next_state;

    logic [2*WORD_SIZE-1:0] cmd_q;
    logic [WORD_SIZE-1:0]   beat_cnt;
    logic [WORD_SIZE-1:0]   beat_next;
    logic [WORD_SIZE-1:0]   num_dma_q;
    logic                   dma_error_q;

    logic                   granted_d, stall_d, cmd_valid_d;
    logic                   granted_q, stall_q, cmd_valid_q;
    logic                   wd_expired;

    // -------------------------------------------------------------------------
    // Optional grant watchdog
    // -------------------------------------------------------------------------
`ifdef ARB_WATCHDOG_EN
    localparam int WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;

    logic wd_load;

    // Reload on GRANT entry so the count covers exactly WATCHDOG_CYCLES
    // cycles spent in GRANT.
    assign wd_load = (next_state == GRANT) && (state != GRANT);

    arb_watchdog #(
        .WIDTH    (WD_W)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .load     (wd_load),
        .load_val (WD_W'(WATCHDOG_CYCLES - 1)),
        .en       (state == GRANT),
        .expired  (wd_expired)
    );
`else
    assign wd_expired = 1'b0;

    // The limit only matters with the watchdog built in; a non-positive value
    // leaves this marker block in the elaborated hierarchy.
    if (WATCHDOG_CYCLES < 1) begin : g_watchdog_cycles_invalid
    end
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment up front keeps every path assigned, so no
    // latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (bus.dma_begin)                         next_state = CMD;
            CMD:                                                next_state = DRAIN;
            DRAIN:   if (bus.bus_request && !bus.cache_busy)    next_state = GRANT;
            GRANT:   if (bus.dma_end || wd_expired)             next_state = RELEASE;
            RELEASE:                                            next_state = IDLE;
            default:                                            next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output logic, decoded from next_state and registered below so the
    // outputs change on the same edge as the state.
    // -------------------------------------------------------------------------
    always_comb begin
        granted_d   = (next_state == GRANT);
        cmd_valid_d = (next_state == CMD);
        stall_d     = 1'b0;
        unique case (next_state)
            DRAIN:          stall_d = bus.bus_request;
            GRANT, RELEASE: stall_d = 1'b1;
            default:        stall_d = 1'b0;
        endcase
    end

    // A beat arriving together with dma_end is included before the length
    // check; the counter saturates rather than wrapping.
    assign beat_next = (bus.dma_beat && (beat_cnt != '1)) ? beat_cnt + 1'b1
                                                          : beat_cnt;

    // -------------------------------------------------------------------------
    // Command register, beat counter, statistics and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            granted_q   <= 1'b0;
            stall_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            beat_cnt    <= '0;
            num_dma_q   <= '0;
            dma_error_q <= 1'b0;
        end else begin
            granted_q   <= granted_d;
            stall_q     <= stall_d;
            cmd_valid_q <= cmd_valid_d;

            // Only IDLE accepts a new command, so a late dma_begin cannot
            // overwrite a transfer in progress.
            if ((state == IDLE) && bus.dma_begin) begin
                cmd_q    <= {bus.cmd_addr, bus.cmd_len};
                beat_cnt <= '0;
            end else if (state == GRANT) begin
                beat_cnt <= beat_next;
            end

            // A normal completion wins over a coincident watchdog expiry.
            if ((state == GRANT) && bus.dma_end) begin
                if (beat_next != cmd_q[WORD_SIZE-1:0]) begin
                    dma_error_q <= 1'b1;
                end
                num_dma_q <= num_dma_q + 1'b1;
            end else if (wd_expired) begin
                dma_error_q <= 1'b1;
            end
        end
    end

    assign bus.bus_granted   = granted_q;
    assign bus.cpu_stall     = stall_q;
    assign bus.dma_cmd       = cmd_q;
    assign bus.dma_cmd_valid = cmd_valid_q;
    assign bus.dma_error     = dma_error_q;
    assign bus.num_dma       = num_dma_q;

endmodule
